axi_lite_regfile: RTL
=====================

// Module: axi_lite_regfile
// PURPOSE
//  Parametrised AXI4-Lite slave register file: NUM_REGS x DATA_WIDTH registers.
//  - Independent, concurrent read and write channels.
//  - AW/W accepted in any order; byte strobes; SLVERR for out-of-range addresses.
//  - Register contents exported flat to fabric for control/config use.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width (axi_pkg::ADDR_WIDTH)
//  DATA_WIDTH  32  data width; 32 or 64 only
//  NUM_REGS    32  number of registers; >=1, need not be a power of 2
//  RESET_VAL   0   reset value of every register (DATA_WIDTH bits)
// PORTS
//  clk      in   1             clock; all logic on posedge
//  rst_n    in   1             asynchronous active-low reset
//  awaddr   in   ADDR_WIDTH    write address
//  awprot   in   3             write protection
//  awvalid  in   1  / awready out 1
//  wdata    in   DATA_WIDTH    write data
//  wstrb    in   DATA_WIDTH/8  byte enables
//  wvalid   in   1  / wready  out 1
//  bresp    out  2             write response
//  bvalid   out  1  / bready  in  1
//  araddr   in   ADDR_WIDTH    read address
//  arprot   in   3             read protection
//  arvalid  in   1  / arready out 1
//  rdata    out  DATA_WIDTH    read data
//  rresp    out  2             read response
//  rvalid   out  1  / rready  in  1
//  regs_o   out  NUM_REGS*DATA_WIDTH  register contents; reg i at [i*DW +: DW]
// BEHAVIOUR
//  Reset: async assert, sync deassert by system. Register contents = RESET_VAL.
//   Outputs during reset: bvalid=0, rvalid=0, rdata=0, bresp=rresp=OKAY,
//   awready=wready=arready=1. Mid-transaction reset abandons it, no response.
//  Decode: idx = addr >> log2(DATA_WIDTH/8); low bits ignored.
//   idx >= NUM_REGS -> resp SLVERR; write dropped; rdata=0.
//  Write FSM: WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP.
//   awready=1 in WR_IDLE/WR_HAVE_W. wready=1 in WR_IDLE/WR_HAVE_AW. Else 0.
//   - Lone AW/W handshake: capture it, move to WR_HAVE_AW/WR_HAVE_W.
//   - Completing handshake (both together in WR_IDLE, or the missing one):
//     register updated on that edge, bytes where wstrb=1 only. Enters WR_RESP.
//   - WR_RESP: bvalid=1, bresp held stable; bvalid&&bready -> WR_IDLE.
//   Latency: AW+W at edge N -> bvalid high in cycle after N.
//  Read FSM: RD_IDLE (arready=1), RD_DATA (rvalid=1, arready=0).
//   - ar handshake at edge N: rdata/rresp registered, rvalid=1 after N.
//   - rdata/rresp stable until rvalid&&rready -> RD_IDLE, rdata cleared to 0.
//   - No read-after-response bubble other than RD_DATA->RD_IDLE (1 cycle).
//  Collision: read and write to same reg completing at one edge -> read
//   returns pre-write value.
//  regs_o: registered; reflects a write the cycle after the write edge.
//  Responses: OKAY=2'b00, SLVERR=2'b10. No EXOKAY/DECERR generated.
// CONFIGURATION
//  AXIL_REGFILE_PROT_EN defined:
//   - awprot[0]=0 (unprivileged) -> write dropped, SLVERR.
//   - arprot[0]=0 -> rdata=0, SLVERR.
//  AXIL_REGFILE_PROT_EN undefined:
//   - awprot/arprot ignored; only range errors produce SLVERR.
// STRUCTURE
//  axi_pkg: ADDR_WIDTH, RESP_OKAY, RESP_SLVERR, axi_resp_t,
//   wr_state_t, rd_state_t enums.
//  Sub-module axi_lite_regfile_decode:
//   - combinational addr -> {idx, in_range, prot_ok}.
//   - instantiated once per channel.
// TESTING
//  Reset: rst_n=0 mid-write -> regs_o all RESET_VAL, bvalid=0, arready=1.
//  AW+W same cycle: addr 0x08, data 0xDEADBEEF, wstrb 0xF
//   -> bvalid next cycle, OKAY; read 0x08 -> 0xDEADBEEF.
//  W before AW by 3 cycles: wdata 0x000000AA, wstrb 0x1 onto 0x11223344
//   -> 0x112233AA.
//  Out of range, NUM_REGS=5: write/read 0x14 -> SLVERR, rdata 0, regs unchanged.
//  Backpressure: bready/rready low 10 cycles -> bvalid/rvalid, data, resp
//   held; no new handshake accepted.
//  Collision: write 0x5 to reg 2 with concurrent read of reg 2 (old 0x3)
//   -> read 0x3; next read 0x5.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4-Lite types: response codes, write/read channel FSM states, index-width helper.
package axi_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef logic [1:0] axi_resp_t;
  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_HAVE_AW = 2'd1,
    WR_HAVE_W  = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  // A single register still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_regfile_decode.sv
// Combinational byte-address to register-index decode with range and privilege check.
// Zero latency; no handshake. Privilege is checked only with AXIL_REGFILE_PROT_EN defined.
module axi_lite_regfile_decode
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = axi_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int IDX_W      = idx_width(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            prot,
  output logic [IDX_W-1:0]      idx,
  output logic                  in_range,
  output logic                  prot_ok
);

  localparam int SHIFT = $clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] w_word;

  assign w_word   = addr >> SHIFT;
  assign in_range = (w_word < ADDR_WIDTH'(NUM_REGS));
  assign idx      = w_word[IDX_W-1:0];

`ifdef AXIL_REGFILE_PROT_EN
  logic w_prot_unused;
  assign w_prot_unused = ^prot[2:1];
  assign prot_ok       = prot[0];
`else
  logic w_prot_unused;
  assign w_prot_unused = ^prot;
  assign prot_ok       = 1'b1;
`endif

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register file, AW/W in any order; B one cycle after the completing edge, R one cycle after AR.
// Channels stall (ready low) while a response is held; optional privilege check via AXIL_REGFILE_PROT_EN.
module axi_lite_regfile
  import axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH = axi_pkg::ADDR_WIDTH,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int IDX_W  = idx_width(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;

  wr_state_t r_wr_state, w_wr_next;
  rd_state_t r_rd_state, w_rd_next;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [IDX_W-1:0]      r_aw_idx;
  logic                  r_aw_ok;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  axi_resp_t             r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [IDX_W-1:0] w_aw_idx, w_ar_idx, w_wr_idx;
  logic             w_aw_rng, w_aw_prot, w_ar_rng, w_ar_prot;
  logic             w_aw_hs, w_w_hs, w_ar_hs, w_wr_done, w_wr_ok, w_ar_ok;
  logic [DATA_WIDTH-1:0] w_wr_data, w_rd_val;
  logic [STRB_W-1:0]     w_wr_strb;

  axi_lite_regfile_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)
  ) u_aw_dec (
    .addr(awaddr), .prot(awprot), .idx(w_aw_idx), .in_range(w_aw_rng), .prot_ok(w_aw_prot)
  );

  axi_lite_regfile_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)
  ) u_ar_dec (
    .addr(araddr), .prot(arprot), .idx(w_ar_idx), .in_range(w_ar_rng), .prot_ok(w_ar_prot)
  );

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  assign w_ar_hs = arvalid && arready;
  assign w_ar_ok = w_ar_rng && w_ar_prot;

  assign w_wr_done = ((r_wr_state == WR_IDLE)    && w_aw_hs && w_w_hs) ||
                     ((r_wr_state == WR_HAVE_AW) && w_w_hs) ||
                     ((r_wr_state == WR_HAVE_W)  && w_aw_hs);

  // The completing beat may be this cycle's handshake or the one captured earlier.
  assign w_wr_idx  = w_aw_hs ? w_aw_idx : r_aw_idx;
  assign w_wr_ok   = w_aw_hs ? (w_aw_rng && w_aw_prot) : r_aw_ok;
  assign w_wr_data = w_w_hs ? wdata : r_wdata;
  assign w_wr_strb = w_w_hs ? wstrb : r_wstrb;

  // Write FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wr_state <= WR_IDLE;
    else        r_wr_state <= w_wr_next;
  end

  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE: begin
        if (w_aw_hs && w_w_hs) w_wr_next = WR_RESP;
        else if (w_aw_hs)      w_wr_next = WR_HAVE_AW;
        else if (w_w_hs)       w_wr_next = WR_HAVE_W;
      end
      WR_HAVE_AW: if (w_w_hs)  w_wr_next = WR_RESP;
      WR_HAVE_W:  if (w_aw_hs) w_wr_next = WR_RESP;
      WR_RESP:    if (bready)  w_wr_next = WR_IDLE;
      default:                 w_wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    awready = (r_wr_state == WR_IDLE) || (r_wr_state == WR_HAVE_W);
    wready  = (r_wr_state == WR_IDLE) || (r_wr_state == WR_HAVE_AW);
    bvalid  = (r_wr_state == WR_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_idx <= '0;
      r_aw_ok  <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_idx <= w_aw_idx;
        r_aw_ok  <= w_aw_rng && w_aw_prot;
      end
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_wr_done) r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_done && w_wr_ok && (w_wr_idx == IDX_W'(i))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_wr_strb[b]) r_regs[i][b*8 +: 8] <= w_wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read FSM; the mux sees pre-write contents, so a same-edge write is not observed.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == IDX_W'(i)) w_rd_val = r_regs[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_state <= RD_IDLE;
    else        r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (w_ar_hs) w_rd_next = RD_DATA;
      RD_DATA: if (rready)  w_rd_next = RD_IDLE;
      default:              w_rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_rd_state == RD_IDLE);
    rvalid  = (r_rd_state == RD_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_ar_ok ? w_rd_val : '0;
      r_rresp <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid && rready) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end
  end

  assign bresp = r_bresp;
  assign rdata = r_rdata;
  assign rresp = r_rresp;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

endmodule
